bcp_implication_scheduler: RTL and testbench
============================================

BCP_IMPLICATION_SCHEDULER -- requirements
Module: bcp_implication_scheduler

Interface
REQ-001 SHALL have parameter NUM_CLAUSES, default 16: number of clause modules observed.
REQ-002 SHALL have parameter MAX_VARIABLE_ID, default 4: highest legal variable ID; ID 0 means unused.
REQ-003 SHALL have parameter VARIABLE_ENCODING_LEN, default $clog2(MAX_VARIABLE_ID+1): variable ID width.
REQ-004 SHALL have parameter CLAUSE_ID_LEN, default $clog2(NUM_CLAUSES): clause index width.
REQ-005 SHALL have port clk_i  input  1  clock; the block uses only rising edges.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port decision_valid_i  input  1  a host decision is offered.
REQ-008 SHALL have port decision_ready_o  output  1  the scheduler can accept a decision.
REQ-009 SHALL have port decision_variable_id_i  input  VARIABLE_ENCODING_LEN  ID of the decision variable.
REQ-010 SHALL have port decision_assignment_i  input  1  value of the decision variable.
REQ-011 SHALL have port update_assignment_o  output  1  one-cycle broadcast strobe to all clause modules.
REQ-012 SHALL have port assign_variable_id_o  output  VARIABLE_ENCODING_LEN  ID being broadcast.
REQ-013 SHALL have port assign_value_o  output  1  value being broadcast.
REQ-014 SHALL have ports clause_unit_i and clause_conflict_i  input  NUM_CLAUSES  per-clause unit and conflict flags.
REQ-015 SHALL have port clause_impl_id_i  input  NUM_CLAUSES*VARIABLE_ENCODING_LEN  implied IDs; clause k occupies slice [k*LEN +: LEN].
REQ-016 SHALL have port clause_impl_assign_i  input  NUM_CLAUSES  implied value for each clause.
REQ-017 SHALL have port busy_o  output  1  the state is not IDLE.
REQ-018 SHALL have ports done_o, conflict_o and error_o  output  1 each  one-cycle completion, conflict and error pulses.
REQ-019 SHALL have port conflict_clause_id_o  output  CLAUSE_ID_LEN  lowest-index conflicting clause, held until the next accepted decision.
REQ-020 SHALL have port implication_count_o  output  VARIABLE_ENCODING_LEN+1  implications broadcast since the last accepted decision.

Function
REQ-021 SHALL implement FSM states IDLE, BROADCAST, SCAN, CONFLICT and DONE.
REQ-022 SHALL assert decision_ready_o only in IDLE; a decision is accepted when decision_valid_i and decision_ready_o are both high at a rising edge.
REQ-023 SHALL, on accepting a legal decision (ID in 1..MAX_VARIABLE_ID), register the ID and value, clear implication_count_o and enter BROADCAST.
REQ-024 SHALL, on accepting an illegal decision (ID 0 or ID > MAX_VARIABLE_ID), stay in IDLE, pulse error_o and broadcast nothing.
REQ-025 SHALL, in BROADCAST (one cycle), drive update_assignment_o=1 with the registered ID and value, then go to SCAN.
REQ-026 SHALL drive update_assignment_o=0 in every state other than BROADCAST.
REQ-027 SHALL, in SCAN, sample the clause inputs, which reflect the preceding broadcast.
REQ-028 SHALL, in SCAN, go to CONFLICT when any conflict bit is set; conflict has priority over unit when both are present in the same cycle.
REQ-029 SHALL, in SCAN with no conflict, select one unit clause per REQ-040/041, register its implied ID and value, increment implication_count_o and go to BROADCAST.
REQ-030 SHALL, in SCAN with no conflict and no unit, go to DONE.
REQ-031 SHALL make each implication cost exactly 2 cycles; a decision with no implications completes with done_o 3 cycles after acceptance.
REQ-032 SHALL, in SCAN, treat implication_count_o == MAX_VARIABLE_ID with a unit pending as a runaway: pulse error_o and go to IDLE without broadcasting.
REQ-033 SHALL, in CONFLICT (one cycle), pulse conflict_o, latch conflict_clause_id_o, then go to IDLE.
REQ-034 SHALL, in DONE (one cycle), pulse done_o, then go to IDLE.
REQ-035 SHALL ignore decision_valid_i while busy_o is high; no queuing.
REQ-036 SHALL broadcast a unit whose implied ID is 0 unchanged; rejecting it is the clause modules' responsibility.

Reset
REQ-037 SHALL, while rst_ni=0 (asynchronous, at any state including mid-broadcast), force IDLE with all outputs 0 (decision_ready_o=1) and the round-robin pointer at 0.
REQ-038 SHALL, when reset releases, accept a decision presented in the first cycle after release.
REQ-039 SHALL NOT reset clause modules; the system-level reset does that.

Configuration
REQ-040 SHALL, with macro BCP_SCHED_ROUND_ROBIN_EN defined, select the first unit clause at or above the pointer (wrapping past NUM_CLAUSES-1 to 0), then set the pointer to the selected index+1 modulo NUM_CLAUSES.
REQ-041 SHALL, without BCP_SCHED_ROUND_ROBIN_EN, select the lowest-index unit clause and hold no pointer.

Structure
REQ-042 SHALL place the state enum and the parameter-derived widths in a shared package, bcp_pkg.
REQ-043 SHALL implement unit selection in a parameterised sub-module bcp_unit_selector (inputs: request vector and pointer; outputs: grant index and grant valid).

Verification
REQ-044 SHALL cover: decision var 1=1 with no clause unit -> one update_assignment_o pulse, done_o 3 cycles after acceptance, implication_count_o=0.
REQ-045 SHALL cover: clause 2 (~1 v 2) is unit after decision 1=1 -> second broadcast of ID 2 value 1, done_o, implication_count_o=1.
REQ-046 SHALL cover: clauses 0 and 3 both in conflict at SCAN -> conflict_o pulse, conflict_clause_id_o=0, no further broadcast.
REQ-047 SHALL cover: units on clauses 1 and 5 in consecutive scans, macro defined -> grants 1 then 5, pointer=6; macro undefined -> grant 1 each time.
REQ-048 SHALL cover: decision ID 0, and separately ID 5 with MAX_VARIABLE_ID=4 -> error_o pulse, no broadcast; a runaway of 5 consecutive units -> error_o after 4 implications.
REQ-049 SHALL cover: rst_ni low during BROADCAST -> update_assignment_o falls without waiting for a clock edge, decision_ready_o=1 after release.

Source files
------------

// File: rtl/bcp_pkg.sv
// rtl/bcp_pkg.sv - shared state encoding and default widths for the BCP implication scheduler
//
// Purpose: holds the scheduler FSM state type and the parameter-derived
// default widths used by bcp_implication_scheduler and bcp_unit_selector.
// Ports: none (package).
package bcp_pkg;

  localparam int BCP_NUM_CLAUSES     = 16;
  localparam int BCP_MAX_VARIABLE_ID = 4;
  localparam int BCP_VAR_LEN         = $clog2(BCP_MAX_VARIABLE_ID + 1);
  localparam int BCP_CLAUSE_ID_LEN   = $clog2(BCP_NUM_CLAUSES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BROADCAST = 3'd1,
    SCAN      = 3'd2,
    CONFLICT  = 3'd3,
    DONE      = 3'd4
  } bcp_state_e;

endpackage

// File: rtl/bcp_unit_selector.sv
// rtl/bcp_unit_selector.sv - rotating first-set selector over a request vector
//
// Purpose: returns the first set request at or above ptr_i, wrapping past
// N-1 back to 0. With ptr_i tied to zero it is a plain lowest-index picker.
// Ports:
//   req_i         [N-1:0]   request vector (one bit per clause)
//   ptr_i         [IDW-1:0] index where the search starts
//   grant_idx_o   [IDW-1:0] selected index (0 when nothing is requested)
//   grant_valid_o           at least one request is set
module bcp_unit_selector
  import bcp_pkg::*;
#(
  parameter int N   = BCP_NUM_CLAUSES,
  parameter int IDW = BCP_CLAUSE_ID_LEN
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] grant_idx_o,
  output logic           grant_valid_o
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    sum           = '0;
    idx           = '0;
    for (int i = 0; i < N; i++) begin
      // Offset i from the pointer, folded back into 0..N-1.
      sum = {1'b0, ptr_i} + (IDW + 1)'(i);
      if (sum >= (IDW + 1)'(N)) begin
        sum = sum - (IDW + 1)'(N);
      end
      idx = sum[IDW-1:0];
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/bcp_implication_scheduler.sv
// rtl/bcp_implication_scheduler.sv - BCP decision/implication broadcast scheduler
//
// Purpose: accepts a host decision, broadcasts it to all clause modules,
// then repeatedly scans clause unit/conflict flags, broadcasting one implied
// assignment per scan until quiescence (done), conflict, or runaway (error).
// Optional feature: define BCP_SCHED_ROUND_ROBIN_EN to pick unit clauses
// round-robin from a rotating pointer; otherwise the lowest index wins.
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   decision_valid_i/ready_o            decision handshake
//   decision_variable_id_i/assignment_i decision payload
//   update_assignment_o                 one-cycle broadcast strobe
//   assign_variable_id_o/value_o        broadcast payload
//   clause_unit_i/conflict_i            per-clause flags
//   clause_impl_id_i/impl_assign_i      per-clause implied literal
//   busy_o                              not idle
//   done_o/conflict_o/error_o           completion pulses
//   conflict_clause_id_o                lowest conflicting clause
//   implication_count_o                 implications since last decision
module bcp_implication_scheduler
  import bcp_pkg::*;
#(
  parameter int NUM_CLAUSES           = BCP_NUM_CLAUSES,
  parameter int MAX_VARIABLE_ID       = BCP_MAX_VARIABLE_ID,
  parameter int VARIABLE_ENCODING_LEN = $clog2(MAX_VARIABLE_ID + 1),
  parameter int CLAUSE_ID_LEN         = $clog2(NUM_CLAUSES)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      decision_valid_i,
  output logic                                      decision_ready_o,
  input  logic [VARIABLE_ENCODING_LEN-1:0]          decision_variable_id_i,
  input  logic                                      decision_assignment_i,
  output logic                                      update_assignment_o,
  output logic [VARIABLE_ENCODING_LEN-1:0]          assign_variable_id_o,
  output logic                                      assign_value_o,
  input  logic [NUM_CLAUSES-1:0]                    clause_unit_i,
  input  logic [NUM_CLAUSES-1:0]                    clause_conflict_i,
  input  logic [NUM_CLAUSES*VARIABLE_ENCODING_LEN-1:0] clause_impl_id_i,
  input  logic [NUM_CLAUSES-1:0]                    clause_impl_assign_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      conflict_o,
  output logic                                      error_o,
  output logic [CLAUSE_ID_LEN-1:0]                  conflict_clause_id_o,
  output logic [VARIABLE_ENCODING_LEN:0]            implication_count_o
);

  bcp_state_e                       state_q;
  logic                             ready_q, busy_q, update_q;
  logic                             done_q, conflict_q, error_q;
  logic [VARIABLE_ENCODING_LEN-1:0] id_q;
  logic                             val_q;
  logic [CLAUSE_ID_LEN-1:0]         cid_q;
  logic [VARIABLE_ENCODING_LEN:0]   count_q;

  logic [CLAUSE_ID_LEN-1:0] ptr;
  logic [CLAUSE_ID_LEN-1:0] unit_idx, conf_idx;
  logic                     unit_valid, conf_valid;
  logic                     decision_legal, at_limit, take_unit;

  bcp_unit_selector #(.N(NUM_CLAUSES), .IDW(CLAUSE_ID_LEN)) u_unit_sel (
    .req_i        (clause_unit_i),
    .ptr_i        (ptr),
    .grant_idx_o  (unit_idx),
    .grant_valid_o(unit_valid)
  );

  // Conflicts always report the lowest index, so the search starts at 0.
  bcp_unit_selector #(.N(NUM_CLAUSES), .IDW(CLAUSE_ID_LEN)) u_conf_sel (
    .req_i        (clause_conflict_i),
    .ptr_i        ('0),
    .grant_idx_o  (conf_idx),
    .grant_valid_o(conf_valid)
  );

  assign decision_legal = (decision_variable_id_i != '0) &&
                          (decision_variable_id_i <= VARIABLE_ENCODING_LEN'(MAX_VARIABLE_ID));
  // Every variable can be implied at most once; more means the clause set is looping.
  assign at_limit  = (count_q == (VARIABLE_ENCODING_LEN + 1)'(MAX_VARIABLE_ID));
  assign take_unit = (state_q == SCAN) && !conf_valid && unit_valid && !at_limit;

`ifdef BCP_SCHED_ROUND_ROBIN_EN
  logic [CLAUSE_ID_LEN-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (take_unit) begin
      ptr_d = (unit_idx == CLAUSE_ID_LEN'(NUM_CLAUSES - 1)) ? '0
                                                            : unit_idx + CLAUSE_ID_LEN'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Outputs are registered alongside the state so each pulse lines up with
  // the cycle its state occupies.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      update_q   <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
      error_q    <= 1'b0;
      id_q       <= '0;
      val_q      <= 1'b0;
      cid_q      <= '0;
      count_q    <= '0;
    end else begin
      update_q   <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
      error_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (decision_valid_i) begin
            if (decision_legal) begin
              state_q  <= BROADCAST;
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
              update_q <= 1'b1;
              id_q     <= decision_variable_id_i;
              val_q    <= decision_assignment_i;
              count_q  <= '0;
              cid_q    <= '0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        BROADCAST: begin
          state_q <= SCAN;
        end
        SCAN: begin
          if (conf_valid) begin
            state_q    <= CONFLICT;
            conflict_q <= 1'b1;
            cid_q      <= conf_idx;
          end else if (unit_valid) begin
            if (at_limit) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q  <= BROADCAST;
              update_q <= 1'b1;
              id_q     <= clause_impl_id_i[int'(unit_idx)*VARIABLE_ENCODING_LEN +: VARIABLE_ENCODING_LEN];
              val_q    <= clause_impl_assign_i[unit_idx];
              count_q  <= count_q + (VARIABLE_ENCODING_LEN + 1)'(1);
            end
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign decision_ready_o     = ready_q;
  assign busy_o               = busy_q;
  assign update_assignment_o  = update_q;
  assign assign_variable_id_o = id_q;
  assign assign_value_o       = val_q;
  assign done_o               = done_q;
  assign conflict_o           = conflict_q;
  assign error_o              = error_q;
  assign conflict_clause_id_o = cid_q;
  assign implication_count_o  = count_q;

endmodule

// File: tb/tb_bcp_implication_scheduler.sv
// tb/tb_bcp_implication_scheduler.sv - directed self-checking bench for bcp_implication_scheduler
module tb_bcp_implication_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        decision_valid;
  logic        decision_ready;
  logic [2:0]  decision_id;
  logic        decision_val;
  logic        update;
  logic [2:0]  a_id;
  logic        a_val;
  logic [15:0] c_unit;
  logic [15:0] c_conf;
  logic [47:0] c_impl_id;
  logic [15:0] c_impl_val;
  logic        busy, done, conflict, error;
  logic [3:0]  cid;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcp_implication_scheduler dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .decision_valid_i      (decision_valid),
    .decision_ready_o      (decision_ready),
    .decision_variable_id_i(decision_id),
    .decision_assignment_i (decision_val),
    .update_assignment_o   (update),
    .assign_variable_id_o  (a_id),
    .assign_value_o        (a_val),
    .clause_unit_i         (c_unit),
    .clause_conflict_i     (c_conf),
    .clause_impl_id_i      (c_impl_id),
    .clause_impl_assign_i  (c_impl_val),
    .busy_o                (busy),
    .done_o                (done),
    .conflict_o            (conflict),
    .error_o               (error),
    .conflict_clause_id_o  (cid),
    .implication_count_o   (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] id, input logic v);
    decision_valid = 1'b1;
    decision_id    = id;
    decision_val   = v;
    step();
    decision_valid = 1'b0;
    decision_id    = 3'd0;
    decision_val   = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    decision_valid = 1'b0;
    decision_id    = 3'd0;
    decision_val   = 1'b0;
    c_unit         = '0;
    c_conf         = '0;
    c_impl_id      = '0;
    c_impl_val     = '0;
    step();
    step();

    // Reset state
    chk("rst_ready", 32'(decision_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_flags", {29'd0, done, conflict, error}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_cid", 32'(cid), 32'd0);
    chk("rst_aid", 32'(a_id), 32'd0);

    // Decision 1=1, no units; presented in the first cycle after release
    rst_n = 1'b1;
    accept(3'd1, 1'b1);
    chk("s1_c1_update", 32'(update), 32'd1);
    chk("s1_c1_id", 32'(a_id), 32'd1);
    chk("s1_c1_val", 32'(a_val), 32'd1);
    chk("s1_c1_busy_ready", {30'd0, busy, decision_ready}, 32'b10);
    step();
    chk("s1_c2_update", 32'(update), 32'd0);
    chk("s1_c2_done", 32'(done), 32'd0);
    step();
    chk("s1_c3_done", 32'(done), 32'd1);
    chk("s1_c3_update", 32'(update), 32'd0);
    chk("s1_c3_count", 32'(count), 32'd0);
    step();
    chk("s1_c4_done", 32'(done), 32'd0);
    chk("s1_c4_ready", 32'(decision_ready), 32'd1);
    chk("s1_c4_busy", 32'(busy), 32'd0);

    // Clause 2 (~1 v 2) becomes unit after 1=1 and implies 2=1
    c_unit[2]         = 1'b1;
    c_impl_id[2*3 +: 3] = 3'd2;
    c_impl_val[2]     = 1'b1;
    accept(3'd1, 1'b1);
    chk("s2_c1_id", 32'(a_id), 32'd1);
    step();
    step();
    chk("s2_c3_update", 32'(update), 32'd1);
    chk("s2_c3_id", 32'(a_id), 32'd2);
    chk("s2_c3_val", 32'(a_val), 32'd1);
    chk("s2_c3_count", 32'(count), 32'd1);
    c_unit = '0;
    step();
    chk("s2_c4_update", 32'(update), 32'd0);
    step();
    chk("s2_c5_done", 32'(done), 32'd1);
    chk("s2_c5_count", 32'(count), 32'd1);
    step();

    // Conflicts on clauses 0 and 3, plus a unit that must lose to them
    c_conf[0] = 1'b1;
    c_conf[3] = 1'b1;
    c_unit[1] = 1'b1;
    accept(3'd2, 1'b0);
    step();
    step();
    chk("s3_conflict", 32'(conflict), 32'd1);
    chk("s3_cid", 32'(cid), 32'd0);
    chk("s3_update", 32'(update), 32'd0);
    chk("s3_done", 32'(done), 32'd0);
    step();
    chk("s3_conflict_end", 32'(conflict), 32'd0);
    chk("s3_ready", 32'(decision_ready), 32'd1);
    chk("s3_update_idle", 32'(update), 32'd0);

    // Conflicts on 3 and 9: lowest index 3, held while idle
    c_conf    = '0;
    c_conf[3] = 1'b1;
    c_conf[9] = 1'b1;
    accept(3'd3, 1'b1);
    step();
    step();
    chk("s3b_cid", 32'(cid), 32'd3);
    step();
    step();
    chk("s3b_cid_held", 32'(cid), 32'd3);
    c_conf = '0;
    c_unit = '0;

    // Units on clauses 1 and 5 in consecutive scans, then 5 and 7
    c_impl_id[1*3 +: 3] = 3'd3;
    c_impl_val[1]       = 1'b0;
    c_impl_id[5*3 +: 3] = 3'd4;
    c_impl_val[5]       = 1'b1;
    c_impl_id[7*3 +: 3] = 3'd1;
    c_impl_val[7]       = 1'b0;
    c_unit[1] = 1'b1;
    c_unit[5] = 1'b1;
    accept(3'd1, 1'b0);
    chk("s4_cid_cleared", 32'(cid), 32'd0);
    step();
    step();
    chk("s4_g1_id", 32'(a_id), 32'd3);
    chk("s4_g1_val", 32'(a_val), 32'd0);
    step();
    step();
`ifdef BCP_SCHED_ROUND_ROBIN_EN
    chk("s4_g2_id", 32'(a_id), 32'd4);
    chk("s4_g2_val", 32'(a_val), 32'd1);
`else
    chk("s4_g2_id", 32'(a_id), 32'd3);
    chk("s4_g2_val", 32'(a_val), 32'd0);
`endif
    chk("s4_g2_update", 32'(update), 32'd1);
    c_unit    = '0;
    c_unit[5] = 1'b1;
    c_unit[7] = 1'b1;
    step();
    step();
`ifdef BCP_SCHED_ROUND_ROBIN_EN
    chk("s4_g3_id", 32'(a_id), 32'd1);
`else
    chk("s4_g3_id", 32'(a_id), 32'd4);
`endif
    chk("s4_g3_count", 32'(count), 32'd3);
    c_unit = '0;
    step();
    step();
    chk("s4_done", 32'(done), 32'd1);
    step();

    // Illegal decisions: ID 0 and ID 5
    accept(3'd0, 1'b1);
    chk("s5_id0_error", 32'(error), 32'd1);
    chk("s5_id0_update", 32'(update), 32'd0);
    chk("s5_id0_busy", 32'(busy), 32'd0);
    step();
    chk("s5_id0_error_end", 32'(error), 32'd0);
    chk("s5_id0_update2", 32'(update), 32'd0);
    accept(3'd5, 1'b1);
    chk("s5_id5_error", 32'(error), 32'd1);
    chk("s5_id5_update", 32'(update), 32'd0);
    chk("s5_id5_ready", 32'(decision_ready), 32'd1);
    step();

    // Runaway: clause 4 stays unit forever
    c_unit[4]           = 1'b1;
    c_impl_id[4*3 +: 3] = 3'd3;
    c_impl_val[4]       = 1'b1;
    accept(3'd4, 1'b1);
    chk("s6_dec_id", 32'(a_id), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      step();
      step();
      chk("s6_impl_update", 32'(update), 32'd1);
      chk("s6_impl_count", 32'(count), 32'(k));
    end
    step();
    step();
    chk("s6_error", 32'(error), 32'd1);
    chk("s6_update", 32'(update), 32'd0);
    chk("s6_count", 32'(count), 32'd4);
    chk("s6_ready", 32'(decision_ready), 32'd1);
    c_unit = '0;
    step();

    // Reset asserted mid-broadcast
    accept(3'd2, 1'b1);
    chk("s7_update_before", 32'(update), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s7_update_async", 32'(update), 32'd0);
    chk("s7_ready_async", 32'(decision_ready), 32'd1);
    chk("s7_busy_async", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    // Pointer must restart at 0: units {1,5} grant clause 1 in both modes
    c_unit[1] = 1'b1;
    c_unit[5] = 1'b1;
    accept(3'd1, 1'b1);
    chk("s7_accept_after_release", 32'(update), 32'd1);
    step();
    step();
    chk("s7_ptr_reset_id", 32'(a_id), 32'd3);
    c_unit = '0;
    step();
    step();
    chk("s7_done", 32'(done), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
